dcache_sram_ctrl: RTL

Access controller for the 512x32 byte-enabled data-cache SRAM (DCACHE_SRAM1 configuration: simple dual-port, unregistered read output, `ASYNC` reset). It shares the single SRAM write port between CPU stores and the line-refill engine, with refill taking priority while a fill is active. It drives the read port for CPU loads and forwards write data on same-address read/write collisions. It sits between the Cortex-M1 data-side pipeline, the refill engine and the DCACHE_SRAM instances.

---
 rtl/dcache_pkg.sv | 9 +
 rtl/dcache_fwd_merge.sv | 20 ++
 rtl/dcache_sram_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared sizes and FSM state type for the data-cache SRAM controller
// Provides DC_ADDR_WIDTH, DC_DATA_WIDTH, DC_BE_WIDTH, DC_LINE_WORDS and dc_state_t.
package dcache_pkg;
    localparam int DC_ADDR_WIDTH = 9;
    localparam int DC_DATA_WIDTH = 32;
    localparam int DC_BE_WIDTH   = 4;
    localparam int DC_LINE_WORDS = 4;
    typedef enum logic {DC_IDLE, DC_FILL} dc_state_t;
endpackage

// File: rtl/dcache_fwd_merge.sv
// dcache_fwd_merge: byte-wise overlay of forwarded write data onto SRAM read data
// Ports: fwd_data/fwd_be - forwarded write word and its byte enables
//        rd_data         - word read from the SRAM
//        merged          - rd_data with every enabled byte taken from fwd_data
module dcache_fwd_merge
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int BE_WIDTH   = DC_BE_WIDTH
)(
    input  logic [DATA_WIDTH-1:0] fwd_data,
    input  logic [BE_WIDTH-1:0]   fwd_be,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] merged
);
    localparam int BW = DATA_WIDTH / BE_WIDTH;
    for (genvar g = 0; g < BE_WIDTH; g++) begin : g_byte
        assign merged[g*BW +: BW] = fwd_be[g] ? fwd_data[g*BW +: BW] : rd_data[g*BW +: BW];
    end
endmodule

// File: rtl/dcache_sram_ctrl.sv
// dcache_sram_ctrl: arbitrates the data-cache SRAM write port between stores and line refill
// Ports: clk/rst_n                 - clock, asynchronous active-low reset
//        st_req/addr/data/be/ready - CPU store handshake
//        ld_req/addr, ld_valid/data - CPU load request and one-cycle-later response
//        rf_start/line, rf_busy/done - line fill control and status
//        rf_valid/data/ready        - refill beat handshake
//        sram_wr_*, sram_rd_addr/data - SRAM write port and read port
module dcache_sram_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int BE_WIDTH   = DC_BE_WIDTH,
    parameter int LINE_WORDS = DC_LINE_WORDS,
    localparam int LW = $clog2(LINE_WORDS)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_req,
    input  logic [ADDR_WIDTH-1:0]    st_addr,
    input  logic [DATA_WIDTH-1:0]    st_data,
    input  logic [BE_WIDTH-1:0]      st_be,
    output logic                     st_ready,
    input  logic                     ld_req,
    input  logic [ADDR_WIDTH-1:0]    ld_addr,
    output logic                     ld_valid,
    output logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     rf_start,
    input  logic [ADDR_WIDTH-LW-1:0] rf_line,
    output logic                     rf_busy,
    input  logic                     rf_valid,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    output logic                     rf_ready,
    output logic                     rf_done,
    output logic                     sram_wr_en,
    output logic [ADDR_WIDTH-1:0]    sram_wr_addr,
    output logic [DATA_WIDTH-1:0]    sram_wr_data,
    output logic [BE_WIDTH-1:0]      sram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0]    sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    sram_rd_data
);
    dc_state_t                state_q, state_d;
    logic [LW-1:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-LW-1:0] line_q, line_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [BE_WIDTH-1:0]      wr_be_q, wr_be_d;
    logic                     ld_valid_q, ld_valid_d;
    logic [DATA_WIDTH-1:0]    fwd_data_q, fwd_data_d;
    logic [BE_WIDTH-1:0]      fwd_be_q, fwd_be_d;
    logic                     rf_done_q, rf_done_d;
    logic                     st_acc, rf_acc, last_beat;
    logic [DATA_WIDTH-1:0]    merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DC_IDLE;
            beat_q     <= '0;
            line_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            ld_valid_q <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
            rf_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            ld_valid_q <= ld_valid_d;
            fwd_data_q <= fwd_data_d;
            fwd_be_q   <= fwd_be_d;
            rf_done_q  <= rf_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        if (state_q == DC_IDLE) begin
            if (rf_start) begin
                state_d = DC_FILL;
                line_d  = rf_line;
                beat_d  = '0;
            end
        end else if (rf_acc) begin
            beat_d  = beat_q + 1'b1;
            state_d = last_beat ? DC_IDLE : DC_FILL;
        end
    end

    always_comb begin
        // rst_n gate keeps st_ready low while reset is held, even with state already IDLE
        st_ready   = rst_n & (state_q == DC_IDLE) & ~rf_start;
        rf_busy    = state_q == DC_FILL;
        rf_ready   = rf_busy;
        st_acc     = st_req & st_ready;
        rf_acc     = rf_valid & rf_ready;
        last_beat  = beat_q == LW'(LINE_WORDS - 1);
        wr_en_d    = st_acc | rf_acc;
        wr_addr_d  = rf_acc ? {line_q, beat_q} : st_addr;
        wr_data_d  = rf_acc ? rf_data : st_data;
        wr_be_d    = rf_acc ? '1 : st_be;
        rf_done_d  = rf_acc & last_beat;
        ld_valid_d = ld_req;
        // the SRAM reads old contents when a write to the same word lands in the same cycle
        fwd_be_d   = (ld_req & wr_en_q & (wr_addr_q == ld_addr)) ? wr_be_q : '0;
        fwd_data_d = wr_data_q;
    end

    dcache_fwd_merge #(.DATA_WIDTH(DATA_WIDTH), .BE_WIDTH(BE_WIDTH)) u_merge (
        .fwd_data (fwd_data_q),
        .fwd_be   (fwd_be_q),
        .rd_data  (sram_rd_data),
        .merged   (merged)
    );

    assign ld_valid        = ld_valid_q;
    assign ld_data         = ld_valid_q ? merged : '0;
    assign rf_done         = rf_done_q;
    assign sram_wr_en      = wr_en_q;
    assign sram_wr_addr    = wr_addr_q;
    assign sram_wr_data    = wr_data_q;
    assign sram_wr_byte_en = wr_be_q;
    assign sram_rd_addr    = ld_addr;
endmodule
